corefifo_graycodec_pipe: RTL and testbench
==========================================

Name: corefifo_graycodec_pipe

Overview:
- Parametrised, pipelined, bidirectional Gray/binary code converter with a valid/ready handshake.
- Selects the conversion direction per beat.
- For Gray-to-binary beats, checks that consecutive Gray inputs are adjacent, catching corrupted synchronised FIFO pointers.
- Sits between the pointer synchronisers and the full/empty/level arithmetic in single-clock or post-sync FIFO logic.

Parameters:
- ADDRWIDTH, 3, code word is ADDRWIDTH+1 bits (N = ADDRWIDTH+1).
- STAGES, 2, pipeline register stages. Legal range 1..N; illegal values are a fatal elaboration error.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rstn  in  1  synchronous reset, active low.
- in_valid  in  1  input beat valid.
- in_ready  out  1  input beat accepted when in_valid && in_ready.
- in_data  in  N  code word.
- in_mode  in  1  0 = Gray to binary, 1 = binary to Gray.
- out_valid  out  1  output beat valid.
- out_ready  in  1  downstream accepts.
- out_data  out  N  converted word.
- out_mode  out  1  in_mode carried with the beat.
- out_err  out  1  adjacency error flag for this beat.
- err_sticky  out  1  OR of all out_err since reset or clear.
- err_clr  in  1  clears err_sticky.

Behaviour:
Reset:
- Clock and reset: one clock (clk); reset (rstn) is synchronous and active-low.
- While rstn=0 at a clock edge: all stage valids, out_valid, out_data, out_mode, out_err, err_sticky and the adjacency reference register are cleared to 0, and the reference is marked invalid.
- in_ready is forced to 0 while rstn=0.
- Reset mid-operation discards all in-flight beats; no output beat appears after reset until a new input is accepted.

Conversion:
- Gray to binary: b[N-1] = g[N-1]; b[i] = b[i+1] ^ g[i].
- The XOR chain is split MSB-first into STAGES segments of ceil(N/STAGES) bits; the last segment takes the remainder.
- Each stage resolves its segment using the carried MSB bit from the previous stage.
- Binary to Gray: g = b ^ (b >> 1), computed in stage 0 and carried unchanged through the remaining stages.

Pipeline and handshake:
- Latency is exactly STAGES cycles from acceptance to out_valid when unstalled.
- Throughput is 1 beat/clk.
- Stage k loads when it is empty or stage k+1 (or downstream for the last stage) accepts in that cycle. Bubbles collapse.
- in_ready = !stage0_valid || stage0_advances. It is combinational from out_ready through the stage valids, with no combinational path from in_valid.
- out_data, out_mode and out_err hold stable while out_valid && !out_ready.
- Beats are never dropped or duplicated; order is preserved.

Adjacency check (stage 0, Gray-to-binary beats only):
- The reference register stores the last accepted mode-0 in_data.
- out_err = 1 if the reference is valid and popcount(in_data ^ ref) > 1.
- Distance 0 (repeat) and 1 are legal.
- The first mode-0 beat after reset has out_err = 0.
- Mode-1 beats never set err and never update the reference.
- Wrap-around (e.g. 1000 -> 0000 for N=4) is distance 1, so it is legal.

err_sticky:
- Set on the cycle an out_err=1 beat is handed off (out_valid && out_ready).
- err_clr clears it. If clear and set coincide, set wins.

Test Plan:
- N=4, STAGES=2, out_ready=1: mode 0, in_data 0110 -> out_data 0100 after exactly 2 clks, out_err=0.
- Mode 1, in_data 1011 -> out_data 1110, out_mode=1. A back-to-back mode 0 then mode 1 stream yields 1 beat/clk in order.
- Mode 0 sequence 0000, 0001, 0011, 0010, 0111 -> out_err 0, 0, 0, 0, 1; err_sticky rises on the 0111 handoff. err_clr alone -> 0. err_clr coincident with a new err beat -> stays 1.
- Mode 0 sequence 1000 then 0000 -> out_err=0 (wrap-around). Repeat 0000 -> out_err=0.
- Hold out_ready=0 for 5 clks with a continuous input stream -> in_ready drops after STAGES beats, out_data stays stable. Release -> all beats delivered in order with no loss.
- Assert rstn=0 for 1 clk with 2 beats in flight -> out_valid=0 and in_ready=0 during reset, no stale beats after. The next mode 0 beat (e.g. 1111) has out_err=0.
- Sweep STAGES = 1, 2, 4 with N=4: all 16 words in both modes match the reference model.

Source files
------------

// File: rtl/corefifo_graycodec_pipe.sv
// Pipelined bidirectional Gray/binary converter with valid/ready handshake.
// Gray-to-binary beats are checked for single-step adjacency against the previous Gray word.
module corefifo_graycodec_pipe #(
    parameter int ADDRWIDTH = 3,
    parameter int STAGES    = 2
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [ADDRWIDTH:0] in_data,
    input  logic               in_mode,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [ADDRWIDTH:0] out_data,
    output logic               out_mode,
    output logic               out_err,
    output logic               err_sticky,
    input  logic               err_clr
);

    localparam int N    = ADDRWIDTH + 1;
    localparam int SDIV = (STAGES < 1) ? 1 : STAGES;
    localparam int SEG  = (N + SDIV - 1) / SDIV;
    localparam int LAST = SDIV - 1;

    generate
        if (STAGES < 1 || STAGES > N) begin : g_bad_stages
            $fatal(1, "corefifo_graycodec_pipe: STAGES must lie in 1..ADDRWIDTH+1");
        end
    endgenerate

    // Resolve one MSB-first segment of the Gray->binary XOR chain; bits above it are already binary.
    function automatic logic [N-1:0] resolve_seg(input logic [N-1:0] w, input int k);
        logic [N-1:0] r;
        int hi;
        int lo;
        r  = w;
        hi = N - 1 - k * SEG;
        lo = hi - SEG + 1;
        for (int i = N - 2; i >= 0; i--) begin
            if (i <= hi && i >= lo) r[i] = r[i] ^ r[i+1];
        end
        return r;
    endfunction

    function automatic logic [N-1:0] bin2gray(input logic [N-1:0] b);
        return b ^ (b >> 1);
    endfunction

    function automatic logic multi_bit(input logic [N-1:0] x);
        int c;
        c = 0;
        for (int i = 0; i < N; i++) begin
            if (x[i]) c++;
        end
        return c > 1;
    endfunction

    logic [SDIV-1:0] vld_p;
    logic [SDIV-1:0] mode_p;
    logic [SDIV-1:0] err_p;
    logic [SDIV-1:0] load;
    logic [N-1:0]    data_p [SDIV];
    logic [N-1:0]    ref_word;
    logic            ref_vld;
    logic            accept;
    logic [N-1:0]    word_p0;
    logic            err_p0;

    // A stage may load when empty or when its content moves on this cycle.
    always_comb begin : handshake
        logic acc;
        acc  = out_ready;
        load = '0;
        for (int k = LAST; k >= 0; k--) begin
            acc     = !vld_p[k] || acc;
            load[k] = acc;
        end
    end

    assign in_ready = rstn && load[0];
    assign accept   = in_valid && in_ready;

    always_comb begin
        word_p0 = in_mode ? bin2gray(in_data) : resolve_seg(in_data, 0);
        err_p0  = !in_mode && ref_vld && multi_bit(in_data ^ ref_word);
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            vld_p    <= '0;
            mode_p   <= '0;
            err_p    <= '0;
            ref_word <= '0;
            ref_vld  <= 1'b0;
            for (int k = 0; k < SDIV; k++) data_p[k] <= '0;
        end else begin
            // stage 0: first segment, Gray encode, adjacency check
            if (load[0]) begin
                vld_p[0] <= accept;
                if (accept) begin
                    data_p[0] <= word_p0;
                    mode_p[0] <= in_mode;
                    err_p[0]  <= err_p0;
                end
            end
            if (accept && !in_mode) begin
                ref_word <= in_data;
                ref_vld  <= 1'b1;
            end
            // stages 1..LAST: remaining segments, Gray-encoded words pass unchanged
            for (int k = 1; k < SDIV; k++) begin
                if (load[k]) begin
                    vld_p[k] <= vld_p[k-1];
                    if (vld_p[k-1]) begin
                        data_p[k] <= mode_p[k-1] ? data_p[k-1] : resolve_seg(data_p[k-1], k);
                        mode_p[k] <= mode_p[k-1];
                        err_p[k]  <= err_p[k-1];
                    end
                end
            end
        end
    end

    assign out_valid = vld_p[LAST];
    assign out_data  = data_p[LAST];
    assign out_mode  = mode_p[LAST];
    assign out_err   = err_p[LAST];

    // Setting on an errored handoff takes priority over a simultaneous clear.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            err_sticky <= 1'b0;
        end else if (out_valid && out_ready && out_err) begin
            err_sticky <= 1'b1;
        end else if (err_clr) begin
            err_sticky <= 1'b0;
        end
    end

endmodule

// File: tb/tb_corefifo_graycodec_pipe.sv
// Scoreboard bench for corefifo_graycodec_pipe: directed steps on STAGES=2, full sweep on STAGES=1/2/4.
module tb_corefifo_graycodec_pipe;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rstn, in_valid, in_mode, out_ready, err_clr;
    logic [3:0] in_data;

    logic       in_ready_s1, out_valid_s1, out_mode_s1, out_err_s1, err_sticky_s1;
    logic       in_ready_s2, out_valid_s2, out_mode_s2, out_err_s2, err_sticky_s2;
    logic       in_ready_s4, out_valid_s4, out_mode_s4, out_err_s4, err_sticky_s4;
    logic [3:0] out_data_s1, out_data_s2, out_data_s4;

    corefifo_graycodec_pipe #(.ADDRWIDTH(3), .STAGES(1)) dut_s1 (
        .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_ready(in_ready_s1),
        .in_data(in_data), .in_mode(in_mode), .out_valid(out_valid_s1), .out_ready(out_ready),
        .out_data(out_data_s1), .out_mode(out_mode_s1), .out_err(out_err_s1),
        .err_sticky(err_sticky_s1), .err_clr(err_clr));

    corefifo_graycodec_pipe #(.ADDRWIDTH(3), .STAGES(2)) dut_s2 (
        .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_ready(in_ready_s2),
        .in_data(in_data), .in_mode(in_mode), .out_valid(out_valid_s2), .out_ready(out_ready),
        .out_data(out_data_s2), .out_mode(out_mode_s2), .out_err(out_err_s2),
        .err_sticky(err_sticky_s2), .err_clr(err_clr));

    corefifo_graycodec_pipe #(.ADDRWIDTH(3), .STAGES(4)) dut_s4 (
        .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_ready(in_ready_s4),
        .in_data(in_data), .in_mode(in_mode), .out_valid(out_valid_s4), .out_ready(out_ready),
        .out_data(out_data_s4), .out_mode(out_mode_s4), .out_err(out_err_s4),
        .err_sticky(err_sticky_s4), .err_clr(err_clr));

    typedef struct {
        logic [3:0] data;
        logic       mode;
        logic       err;
        int         cyc;
        bit         lat;
    } exp_t;

    exp_t q1[$];
    exp_t q2[$];
    exp_t q4[$];

    int         checks = 0;
    int         errors = 0;
    int         cyc = 0;
    bit         lat_on = 1'b1;
    bit         sweep_on = 1'b0;
    logic [3:0] m_ref = 4'h0;
    bit         m_ref_vld = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [3:0] m_g2b(input logic [3:0] g);
        logic [3:0] b;
        b[3] = g[3];
        for (int i = 2; i >= 0; i--) b[i] = b[i+1] ^ g[i];
        return b;
    endfunction

    function automatic logic [3:0] m_b2g(input logic [3:0] b);
        return {b[3], b[3] ^ b[2], b[2] ^ b[1], b[1] ^ b[0]};
    endfunction

    function automatic int m_dist(input logic [3:0] x);
        int c;
        c = 0;
        for (int i = 0; i < 4; i++) if (x[i]) c++;
        return c;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic push(input logic [3:0] d, input logic m, input int c);
        exp_t e;
        e.data = m ? m_b2g(d) : m_g2b(d);
        e.mode = m;
        e.err  = !m && m_ref_vld && (m_dist(d ^ m_ref) > 1);
        e.cyc  = c;
        e.lat  = lat_on;
        if (!m) begin
            m_ref     = d;
            m_ref_vld = 1'b1;
        end
        q2.push_back(e);
        if (sweep_on) begin
            q1.push_back(e);
            q4.push_back(e);
        end
    endtask

    task automatic mon_cmp(input string pfx, input exp_t e, input logic [3:0] d,
                           input logic m, input logic er, input int stg);
        chk({pfx, "_data"}, 32'(d), 32'(e.data));
        chk({pfx, "_mode"}, 32'(m), 32'(e.mode));
        chk({pfx, "_err"}, 32'(er), 32'(e.err));
        if (e.lat) chk({pfx, "_latency"}, cyc - e.cyc, stg);
    endtask

    always @(negedge clk) begin
        if (rstn && out_valid_s2 && out_ready) begin
            checks++;
            assert (q2.size() > 0) else begin
                errors++;
                $error("FAIL s2_extra_beat observed=%0h expected=no-beat", out_data_s2);
            end
            if (q2.size() > 0) mon_cmp("s2", q2.pop_front(), out_data_s2, out_mode_s2, out_err_s2, 2);
        end
    end

    always @(negedge clk) begin
        if (sweep_on && rstn && out_valid_s1 && out_ready) begin
            checks++;
            assert (q1.size() > 0) else begin
                errors++;
                $error("FAIL s1_extra_beat observed=%0h expected=no-beat", out_data_s1);
            end
            if (q1.size() > 0) mon_cmp("s1", q1.pop_front(), out_data_s1, out_mode_s1, out_err_s1, 1);
        end
    end

    always @(negedge clk) begin
        if (sweep_on && rstn && out_valid_s4 && out_ready) begin
            checks++;
            assert (q4.size() > 0) else begin
                errors++;
                $error("FAIL s4_extra_beat observed=%0h expected=no-beat", out_data_s4);
            end
            if (q4.size() > 0) mon_cmp("s4", q4.pop_front(), out_data_s4, out_mode_s4, out_err_s4, 4);
        end
    end

    task automatic send(input logic [3:0] d, input logic m, output int waits);
        bit done;
        done     = 1'b0;
        waits    = 0;
        in_valid = 1'b1;
        in_data  = d;
        in_mode  = m;
        while (!done && waits < 40) begin
            @(negedge clk);
            if (in_ready_s2) begin
                if (sweep_on) begin
                    chk("s1_in_ready", 32'(in_ready_s1), 1);
                    chk("s4_in_ready", 32'(in_ready_s4), 1);
                end
                push(d, m, cyc);
                done = 1'b1;
            end else begin
                waits++;
            end
            @(posedge clk);
            #1;
        end
        chk("send_accepted", 32'(done), 1);
    endtask

    task automatic drain();
        int n;
        n = 0;
        in_valid = 1'b0;
        while ((q2.size() > 0 || (sweep_on && (q1.size() > 0 || q4.size() > 0))) && n < 60) begin
            @(posedge clk);
            n++;
        end
        #1;
        chk("drain_s2", q2.size(), 0);
    endtask

    task automatic wait_out();
        int n;
        n = 0;
        @(negedge clk);
        while (!out_valid_s2 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("out_valid_seen", 32'(out_valid_s2), 1);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rstn     = 1'b0;
        in_valid = 1'b0;
        q1.delete();
        q2.delete();
        q4.delete();
        m_ref     = 4'h0;
        m_ref_vld = 1'b0;
        @(posedge clk);
        #1;
        rstn = 1'b1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired observed=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int         w;
        int         acc;
        int         idx;
        bit         held_seen;
        logic [3:0] held;
        logic [3:0] sd [6];

        rstn      = 1'b0;
        in_valid  = 1'b0;
        in_data   = 4'h0;
        in_mode   = 1'b0;
        out_ready = 1'b1;
        err_clr   = 1'b0;

        // reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_out_valid", 32'(out_valid_s2), 0);
        chk("rst_in_ready", 32'(in_ready_s2), 0);
        chk("rst_sticky", 32'(err_sticky_s2), 0);
        chk("rst_out_data", 32'(out_data_s2), 0);
        chk("rst_out_err", 32'(out_err_s2), 0);
        @(posedge clk);
        #1;
        rstn = 1'b1;

        // single beats in each direction
        send(4'b0110, 1'b0, w);
        in_valid = 1'b0;
        wait_out();
        chk("g2b_0110", 32'(out_data_s2), 32'(4'b0100));
        chk("g2b_0110_err", 32'(out_err_s2), 0);
        @(posedge clk);
        #1;
        send(4'b1011, 1'b1, w);
        in_valid = 1'b0;
        wait_out();
        chk("b2g_1011", 32'(out_data_s2), 32'(4'b1110));
        chk("b2g_1011_mode", 32'(out_mode_s2), 1);
        @(posedge clk);
        #1;

        // back-to-back mixed stream
        send(4'b0111, 1'b0, w);
        send(4'b0011, 1'b1, w);
        chk("tput_1", w, 0);
        send(4'b0101, 1'b0, w);
        chk("tput_2", w, 0);
        send(4'b1001, 1'b1, w);
        chk("tput_3", w, 0);
        drain();

        // adjacency errors and err_sticky
        do_reset();
        send(4'b0000, 1'b0, w);
        send(4'b0001, 1'b0, w);
        send(4'b0011, 1'b0, w);
        send(4'b0010, 1'b0, w);
        drain();
        @(negedge clk);
        chk("sticky_before", 32'(err_sticky_s2), 0);
        @(posedge clk);
        #1;
        send(4'b0111, 1'b0, w);
        drain();
        @(negedge clk);
        chk("sticky_set", 32'(err_sticky_s2), 1);
        @(posedge clk);
        #1;
        err_clr = 1'b1;
        @(posedge clk);
        #1;
        err_clr = 1'b0;
        @(negedge clk);
        chk("sticky_clr", 32'(err_sticky_s2), 0);
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        lat_on    = 1'b0;
        send(4'b0000, 1'b0, w);
        in_valid = 1'b0;
        wait_out();
        @(posedge clk);
        #1;
        err_clr   = 1'b1;
        out_ready = 1'b1;
        lat_on    = 1'b1;
        @(posedge clk);
        #1;
        err_clr = 1'b0;
        @(negedge clk);
        chk("sticky_set_wins", 32'(err_sticky_s2), 1);

        // wrap-around and repeat are legal
        @(posedge clk);
        #1;
        err_clr = 1'b1;
        @(posedge clk);
        #1;
        err_clr = 1'b0;
        send(4'b1000, 1'b0, w);
        send(4'b0000, 1'b0, w);
        send(4'b0000, 1'b0, w);
        drain();
        @(negedge clk);
        chk("wrap_sticky", 32'(err_sticky_s2), 0);

        // downstream stall with a continuous input stream
        sd = '{4'h3, 4'h5, 4'h9, 4'hC, 4'hA, 4'h6};
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        lat_on    = 1'b0;
        acc       = 0;
        idx       = 0;
        held_seen = 1'b0;
        held      = 4'h0;
        in_valid  = 1'b1;
        in_mode   = 1'b1;
        in_data   = sd[0];
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            if (out_valid_s2) begin
                if (!held_seen) begin
                    held      = out_data_s2;
                    held_seen = 1'b1;
                end else begin
                    chk("stall_hold", 32'(out_data_s2), 32'(held));
                end
            end
            if (in_ready_s2 && idx < 6) begin
                push(sd[idx], 1'b1, cyc);
                idx++;
                acc++;
            end
            @(posedge clk);
            #1;
            if (idx < 6) in_data = sd[idx];
        end
        chk("stall_accepted", acc, 2);
        @(negedge clk);
        chk("stall_in_ready", 32'(in_ready_s2), 0);
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        lat_on    = 1'b1;
        for (int j = idx; j < 6; j++) send(sd[j], 1'b1, w);
        drain();

        // reset with two beats in flight
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        lat_on    = 1'b0;
        send(4'b0001, 1'b1, w);
        send(4'b0010, 1'b1, w);
        rstn     = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        chk("midrst_in_ready", 32'(in_ready_s2), 0);
        @(posedge clk);
        #1;
        rstn      = 1'b1;
        out_ready = 1'b1;
        lat_on    = 1'b1;
        q2.delete();
        m_ref     = 4'h0;
        m_ref_vld = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("midrst_no_stale", 32'(out_valid_s2), 0);
        end
        @(posedge clk);
        #1;
        send(4'b1111, 1'b0, w);
        drain();

        // all words, both directions, three pipeline depths
        sweep_on = 1'b1;
        do_reset();
        for (int i = 0; i < 16; i++) send(4'(i), 1'b0, w);
        for (int i = 0; i < 16; i++) send(4'(i), 1'b1, w);
        drain();
        chk("drain_s1", q1.size(), 0);
        chk("drain_s4", q4.size(), 0);
        @(negedge clk);
        chk("sweep_sticky_s1", 32'(err_sticky_s1), 1);
        chk("sweep_sticky_s4", 32'(err_sticky_s4), 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
